rf_scoreboard_ctrl: RTL

Scoreboard and hazard controller for the general register file in the 5-stage pipeline. It counts, per architectural register, the writes issued past ID that have not yet committed at the WB write port. It raises a stall to ID whenever a decoded source register has a pending write. It sits beside ID and takes its retire inputs directly from the WB stage's rf_we/rf_waddr outputs.

---
 rtl/rf_scoreboard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/rf_scoreboard_ctrl.sv
// Register-file scoreboard: per-register pending-write counters, ID hazard stall,
// total in-flight write count and sticky overflow/underflow error flags.
module rf_scoreboard_ctrl #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [4:0]       issue_dest,
    input  logic             retire_we,
    input  logic [4:0]       retire_dest,
    input  logic             flush,
    input  logic [4:0]       rs1,
    input  logic             rs1_used,
    input  logic [4:0]       rs2,
    input  logic             rs2_used,
    output logic             id_stall,
    output logic [TOT_W-1:0] inflight_cnt,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
    localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1'b1);

    // Entry 0 is never written after reset, so x0 always reads as zero.
    logic [CNT_W-1:0] cnt [0:31];

    logic inc_hit_s;
    logic dec_hit_s;
    logic same_reg_s;
    logic inc_eff_s;
    logic dec_eff_s;
    logic inc_sat_s;
    logic dec_zero_s;

    // Classify this cycle's issue/retire: effective count change or error event.
    always_comb begin
        inc_hit_s  = issue_valid & issue_we & (issue_dest != 5'd0);
        dec_hit_s  = retire_we & (retire_dest != 5'd0);
        same_reg_s = inc_hit_s & dec_hit_s & (issue_dest == retire_dest);
        inc_eff_s  = 1'b0;
        inc_sat_s  = 1'b0;
        dec_eff_s  = 1'b0;
        dec_zero_s = 1'b0;
        if (inc_hit_s && !same_reg_s) begin
            inc_eff_s = (cnt[issue_dest] != CNT_MAX);
            inc_sat_s = (cnt[issue_dest] == CNT_MAX);
        end else begin
            inc_eff_s = 1'b0;
        end
        if (dec_hit_s && !same_reg_s) begin
            dec_eff_s  = (cnt[retire_dest] != CNT_ZERO);
            dec_zero_s = (cnt[retire_dest] == CNT_ZERO);
        end else begin
            dec_eff_s = 1'b0;
        end
    end

    // Hazard stall looks only at registered counts, so same-cycle issue/retire act next cycle.
    always_comb begin
        id_stall = 1'b0;
        if (rs1_used && (rs1 != 5'd0) && (cnt[rs1] != CNT_ZERO)) begin
            id_stall = 1'b1;
        end else if (rs2_used && (rs2 != 5'd0) && (cnt[rs2] != CNT_ZERO)) begin
            id_stall = 1'b1;
        end else begin
            id_stall = 1'b0;
        end
    end

    // Counter, total and sticky-flag state; flush outranks issue/retire but keeps the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= CNT_ZERO;
            end
            inflight_cnt  <= TOT_ZERO;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= CNT_ZERO;
            end
            inflight_cnt <= TOT_ZERO;
        end else begin
            if (inc_eff_s) begin
                cnt[issue_dest] <= cnt[issue_dest] + CNT_ONE;
            end
            if (dec_eff_s) begin
                cnt[retire_dest] <= cnt[retire_dest] - CNT_ONE;
            end
            if (inc_eff_s && !dec_eff_s && (inflight_cnt != TOT_MAX)) begin
                inflight_cnt <= inflight_cnt + TOT_ONE;
            end else if (dec_eff_s && !inc_eff_s && (inflight_cnt != TOT_ZERO)) begin
                inflight_cnt <= inflight_cnt - TOT_ONE;
            end
            if (inc_sat_s) begin
                err_overflow <= 1'b1;
            end
            if (dec_zero_s) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
